memshare_l1pa_read_seqr: RTL

- Drives read bursts into the memShare type-0 L1PA register file (`memShare_regFile_wrapper`) on its port 0, one page address per cycle.
- Issues the per-burst `deltaPipe_rstn` clear pulse.
- Realigns the returning {l1pa_shift, shift_delta, isGtr} triples to a valid/ready stream for the layered decoder's shift-control consumer.
- A credit-limited skid FIFO absorbs the fixed register-file read latency under backpressure, so no read result is ever dropped.

---
 rtl/memshare_l1pa_read_seqr.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/memshare_l1pa_read_seqr.sv
`default_nettype none
// ============================================================================
// memshare_l1pa_read_seqr : burst read sequencer for the memShare type-0 L1PA
// register file, with a credit-limited skid FIFO feeding a valid/ready stream.
// Rev 1.0
// ============================================================================
module memshare_l1pa_read_seqr #(
   parameter int SHIFT_BITWIDTH      = 3,
   parameter int DELTA_BITWIDTH      = 3,
   parameter int TYPE0_ADDR_BITWIDTH = 5,
   parameter int TYPE0_PAGE_NUM      = 32,
   parameter int REGFILE_RD_CYCLE    = 1,
   parameter int FIFO_DEPTH          = REGFILE_RD_CYCLE + 2
) (
   input  logic                            sys_clk,
   input  logic                            rstn,
   input  logic                            start_i,
   input  logic [TYPE0_ADDR_BITWIDTH-1:0]  base_page_i,
   input  logic [TYPE0_ADDR_BITWIDTH:0]    page_cnt_i,
   output logic                            busy_o,
   output logic                            done_o,
   output logic [TYPE0_ADDR_BITWIDTH-1:0]  regType0_raddr_o,
   output logic                            deltaPipe_rstn_o,
   input  logic [SHIFT_BITWIDTH-1:0]       l1pa_shift_i,
   input  logic [DELTA_BITWIDTH-1:0]       shift_delta_i,
   input  logic                            isGtr_i,
   output logic                            out_valid_o,
   input  logic                            out_ready_i,
   output logic [SHIFT_BITWIDTH-1:0]       out_shift_o,
   output logic [DELTA_BITWIDTH-1:0]       out_delta_o,
   output logic                            out_isGtr_o,
   output logic                            out_last_o
);

   localparam int A_W   = TYPE0_ADDR_BITWIDTH;
   localparam int RD    = REGFILE_RD_CYCLE;
   localparam int ENT_W = SHIFT_BITWIDTH + DELTA_BITWIDTH + 2;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [A_W-1:0]   C_LAST_PAGE = A_W'(TYPE0_PAGE_NUM - 1);
   localparam logic [PTR_W-1:0] C_LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] C_FULL_CNT  = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W:0]   C_CREDITS   = (CNT_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLR   = 2'd1,
      S_ISSUE = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t           state_q;
   logic [A_W-1:0]   page_q;
   logic [A_W-1:0]   raddr_q;
   logic [A_W:0]     remain_q;
   logic             busy_q;
   logic             done_q;
   logic             dp_rstn_q;

   logic [RD-1:0]    tag_vld_q;
   logic [RD-1:0]    tag_last_q;
   logic [CNT_W-1:0] inflight_q;

   logic [ENT_W-1:0] fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wptr_q;
   logic [PTR_W-1:0] rptr_q;
   logic [CNT_W-1:0] fifo_cnt_q;

   logic             w_issue;
   logic             w_last_issue;
   logic             w_cap;
   logic             w_pop;
   logic             w_drain_done;
   logic [CNT_W:0]   w_outstanding;

   // Every read in flight or parked in the FIFO holds one credit.
   assign w_outstanding = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
   assign w_issue       = (state_q == S_ISSUE) && (w_outstanding < C_CREDITS);
   assign w_last_issue  = (remain_q == (A_W + 1)'(1));
   assign w_cap         = tag_vld_q[RD-1];
   assign w_pop         = (fifo_cnt_q != '0) && out_ready_i;
   assign w_drain_done  = (inflight_q == '0) &&
                          ((fifo_cnt_q == '0) || ((fifo_cnt_q == CNT_W'(1)) && w_pop));

   // The address reaches the regfile in the issue cycle itself.
   assign regType0_raddr_o = w_issue ? page_q : raddr_q;
   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign deltaPipe_rstn_o = dp_rstn_q;
   assign out_valid_o      = (fifo_cnt_q != '0);
   assign {out_shift_o, out_delta_o, out_isGtr_o, out_last_o} = fifo_mem_q[rptr_q];

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         page_q    <= '0;
         raddr_q   <= '0;
         remain_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dp_rstn_q <= 1'b1;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  if (page_cnt_i == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     page_q    <= base_page_i;
                     remain_q  <= page_cnt_i;
                     busy_q    <= 1'b1;
                     dp_rstn_q <= 1'b0;
                     state_q   <= S_CLR;
                  end
               end
            end
            S_CLR: begin
               dp_rstn_q <= 1'b1;
               state_q   <= S_ISSUE;
            end
            S_ISSUE: begin
               if (w_issue) begin
                  raddr_q  <= page_q;
                  page_q   <= (page_q == C_LAST_PAGE) ? '0 : page_q + A_W'(1);
                  remain_q <= remain_q - (A_W + 1)'(1);
                  if (w_last_issue) begin
                     state_q <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (w_drain_done) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Tag pipeline mirrors the regfile read latency.
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         tag_vld_q  <= '0;
         tag_last_q <= '0;
         inflight_q <= '0;
      end else begin
         tag_vld_q[0]  <= w_issue;
         tag_last_q[0] <= w_issue && w_last_issue;
         for (int i = 1; i < RD; i++) begin
            tag_vld_q[i]  <= tag_vld_q[i-1];
            tag_last_q[i] <= tag_last_q[i-1];
         end
         case ({w_issue, w_cap})
            2'b10:   inflight_q <= inflight_q + CNT_W'(1);
            2'b01:   inflight_q <= inflight_q - CNT_W'(1);
            default: inflight_q <= inflight_q;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_q[i] <= '0;
         end
         wptr_q     <= '0;
         rptr_q     <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (w_cap) begin
            fifo_mem_q[wptr_q] <= {l1pa_shift_i, shift_delta_i, isGtr_i, tag_last_q[RD-1]};
            wptr_q             <= (wptr_q == C_LAST_PTR) ? '0 : wptr_q + PTR_W'(1);
         end
         if (w_pop) begin
            rptr_q <= (rptr_q == C_LAST_PTR) ? '0 : rptr_q + PTR_W'(1);
         end
         case ({w_cap, w_pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge sys_clk) disable iff (!rstn)
      !(w_cap && (fifo_cnt_q == C_FULL_CNT)));

endmodule

`default_nettype wire
